// File: rtl/fifo_drain_arb_pkg.sv
// fifo_drain_arb_pkg: shared arbiter FSM state and channel-index width helper.
package fifo_drain_arb_pkg;
  typedef enum logic {IDLE, LOCK} state_e;
  function automatic int chw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_drain_arb_rr_pick.sv
// rr_pick: first set bit of elig_i searching upward from last_i+1, modulo NCH.
module rr_pick #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] elig_i,
  input  logic [CHW-1:0] last_i,
  output logic [CHW-1:0] idx_o,
  output logic           found_o
);
  logic [2*NCH-1:0] dbl;
  logic [CHW:0]     s;
  always_comb begin
    dbl = {elig_i, elig_i} >> ({1'b0, last_i} + 1'b1);
    s = '0;
    found_o = 1'b0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        s = {1'b0, last_i} + 1'b1 + (CHW+1)'(j);
        found_o = 1'b1;
      end
    end
    idx_o = (s >= (CHW+1)'(NCH)) ? CHW'(s - (CHW+1)'(NCH)) : s[CHW-1:0];
  end
endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb: burst round-robin drain of NCH show-ahead FIFOs into one registered stream.
// Define FIFO_DRAIN_ARB_PRIO_EN to make channel 0 strict high priority.
module fifo_drain_arb
  import fifo_drain_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  localparam int CHW   = chw(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        fifo_empty,
  input  logic [NCH*DWIDTH-1:0] fifo_rdata,
  output logic [NCH-1:0]        fifo_rd,
  output logic                  m_valid,
  output logic [DWIDTH-1:0]     m_data,
  output logic [CHW-1:0]        m_ch,
  input  logic                  m_ready
);
  state_e            state_q;
  logic [CHW-1:0]    g_q, last_q, m_ch_q, pick, gnt;
  logic [3:0]        cnt_q, cnt_d;
  logic [NCH-1:0]    elig;
  logic [DWIDTH-1:0] m_data_q, rdata_sel;
  logic              m_valid_q, found, gnt_ok, xfer, burst_end;

  assign elig = ch_en & ~fifo_empty;

  rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
    .elig_i (elig),
    .last_i (last_q),
    .idx_o  (pick),
    .found_o(found)
  );

`ifdef FIFO_DRAIN_ARB_PRIO_EN
  assign gnt       = (state_q == LOCK) ? g_q : (elig[0] ? '0 : pick);
  assign burst_end = (cnt_d == 4'(BURST)) | ((state_q == LOCK) & (g_q != '0) & elig[0]);
`else
  assign gnt       = (state_q == LOCK) ? g_q : pick;
  assign burst_end = cnt_d == 4'(BURST);
`endif

  assign gnt_ok  = (state_q == LOCK) ? elig[g_q] : found;
  assign cnt_d   = (state_q == LOCK) ? cnt_q + 4'd1 : 4'd1;
  // Pop is combinational so the show-ahead word and its pop share one edge.
  assign xfer    = ~rst & (~m_valid_q | m_ready) & gnt_ok;
  assign fifo_rd = xfer ? (NCH'(1) << gnt) : '0;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NCH; i++)
      rdata_sel = (gnt == CHW'(i)) ? fifo_rdata[i*DWIDTH +: DWIDTH] : rdata_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= CHW'(NCH - 1);
      g_q       <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      if (xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= rdata_sel;
        m_ch_q    <= gnt;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (xfer && burst_end) begin
        state_q <= IDLE;
        last_q  <= gnt;
        cnt_q   <= '0;
      end else if (xfer) begin
        state_q <= LOCK;
        g_q     <= gnt;
        cnt_q   <= cnt_d;
      end else if (state_q == LOCK && !elig[g_q]) begin
        state_q <= IDLE;
        last_q  <= g_q;
        cnt_q   <= '0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;
endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb_fifo_drain_arb: directed checks of fifo_drain_arb with NCH=4, DWIDTH=8, BURST=4.
`timescale 1ns/1ps
module tb_fifo_drain_arb;
  import fifo_drain_arb_pkg::*;
  localparam int NCH = 4;
  localparam int DW  = 8;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m_ready = 1'b1;
  logic              m_valid;
  logic [NCH-1:0]    ch_en = 4'hF;
  logic [NCH-1:0]    fifo_empty, fifo_rd;
  logic [NCH*DW-1:0] fifo_rdata;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_ch;
  logic [7:0]        mem [NCH][256];
  int                rp [NCH];
  int                wp [NCH];
  int                got [$];
  int                nerr = 0;
  int                nchk = 0;

  always #5 clk = ~clk;

  fifo_drain_arb #(.NCH(NCH), .DWIDTH(DW), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ch      (m_ch),
    .m_ready   (m_ready)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_fifo
    assign fifo_empty[c]           = rp[c] == wp[c];
    assign fifo_rdata[c*DW +: DW]  = mem[c][rp[c][7:0]];
  end

  always @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (fifo_rd[c]) rp[c] <= rp[c] + 1;

  // Inputs change only just after posedge, so this sees the accept condition of the next edge.
  always @(negedge clk)
    if (m_valid && m_ready) got.push_back(int'({m_ch, m_data}));

  task automatic check(input string tag, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wp[c][7:0]] = 8'(c * 16 + k);
      wp[c]++;
    end
  endtask

  function automatic int cnt(input int c);
    return wp[c] - rp[c];
  endfunction

  function automatic int w(input int c, input int k);
    return c * 256 + c * 16 + k;
  endfunction

  function automatic int exp_a(input int i);
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    return (i < 8) ? w(0, i) : w(1 + ((i - 8) / 4) % 3, ((i - 8) / 12) * 4 + (i - 8) % 4);
`else
    return w((i / 4) % 4, (i / 16) * 4 + i % 4);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gaps, bad;
    int f_exp [5];
    for (int c = 0; c < NCH; c++) fill(c, 8);
    step(3);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ch", m_ch, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_last", dut.last_q, 3);
    rst = 1'b0;
    gaps = 0;
    repeat (32) begin
      step(1);
      gaps += int'(!m_valid);
    end
    step(2);
    check("a_gaps", gaps, 0);
    check("a_count", got.size(), 32);
    for (int i = 0; i < 32; i++) check($sformatf("a_word%0d", i), got[i], exp_a(i));
    got.delete();
    fill(2, 3);
    step(6);
    check("b_count", got.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("b_word%0d", i), got[i], w(2, i));
    check("b_valid", m_valid, 0);
    check("b_state", dut.state_q, IDLE);
    check("b_last", dut.last_q, 2);
    m_ready = 1'b0;
    got.delete();
    fill(1, 3);
    step(1);
    check("c_load", m_data, 8'h10);
    bad = 0;
    repeat (5) begin
      step(1);
      bad += int'(!m_valid || m_data != 8'h10 || m_ch != 2'd1 || fifo_rd != '0);
    end
    check("c_hold", bad, 0);
    check("c_left", cnt(1), 2);
    check("c_none", got.size(), 0);
    m_ready = 1'b1;
    step(6);
    check("c_count", got.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("c_word%0d", i), got[i], w(1, i));
    got.delete();
    fill(1, 8);
    step(2);
    ch_en = 4'b1101;
    fill(2, 2);
    step(5);
    check("d_left", cnt(1), 6);
    check("d_count", got.size(), 4);
    check("d_word0", got[0], w(1, 0));
    check("d_word1", got[1], w(1, 1));
    check("d_word2", got[2], w(2, 0));
    check("d_word3", got[3], w(2, 1));
    ch_en = 4'hF;
    wp[1] = rp[1];
    fill(3, 8);
    step(2);
    rst = 1'b1;
    fill(0, 4);
    step(1);
    check("e_valid", m_valid, 0);
    check("e_rd", fifo_rd, 0);
    check("e_left", cnt(3), 6);
    rst = 1'b0;
    step(1);
    check("e_ch", m_ch, 0);
    check("e_data", m_data, 8'h00);
    check("e_vld", m_valid, 1);
    for (int c = 0; c < NCH; c++) wp[c] = rp[c];
    step(2);
    got.delete();
    fill(2, 8);
    step(2);
    fill(0, 4);
    step(8);
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    f_exp = '{w(2, 0), w(2, 1), w(2, 2), w(0, 0), w(0, 1)};
`else
    f_exp = '{w(2, 0), w(2, 1), w(2, 2), w(2, 3), w(0, 0)};
`endif
    for (int i = 0; i < 5; i++) check($sformatf("f_word%0d", i), got[i], f_exp[i]);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fifo_drain_arb.md
FIFO_DRAIN_ARB -- requirements
Module: fifo_drain_arb

Interface
REQ-001 Parameter NCH, default 4, number of source FIFO channels (2..8).
REQ-002 Parameter DWIDTH, default 8, data width per channel.
REQ-003 Parameter BURST, default 4, maximum consecutive words from one channel before rotation (1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ch_en  input  NCH  per-channel enable mask.
REQ-007 fifo_empty  input  NCH  empty flag of each source FIFO.
REQ-008 fifo_rdata  input  NCH*DWIDTH  show-ahead read data; channel i occupies bits [i*DWIDTH +: DWIDTH].
REQ-009 fifo_rd  output  NCH  one-hot pop strobe to the source FIFOs.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_data  output  DWIDTH  output word.
REQ-012 m_ch  output  CHW  source channel of m_data, where CHW = clog2(NCH).
REQ-013 m_ready  input  1  downstream accept.

Function
REQ-014 Channel i SHALL be eligible when ch_en[i] & ~fifo_empty[i].
REQ-015 The output register SHALL load when (~m_valid | m_ready) and the granted channel is eligible; a load is a transfer.
REQ-016 On a transfer, fifo_rd[g] SHALL be 1 for exactly that cycle; m_data and m_ch SHALL capture fifo_rdata[g] and g at the same edge (latency 1 cycle).
REQ-017 fifo_rd SHALL be at most one-hot, SHALL be 0 for every ineligible channel, and SHALL be 0 when the output is stalled (m_valid & ~m_ready).
REQ-018 m_valid SHALL clear on the edge where m_ready=1 and no transfer occurs; m_data and m_ch SHALL hold while m_valid & ~m_ready.
REQ-019 The arbiter FSM SHALL have two states, IDLE and LOCK.
REQ-020 IDLE: the grant SHALL be the first eligible channel searching from last+1 upward, modulo NCH; on a transfer the FSM SHALL enter LOCK with g set to that channel and burst count = 1.
REQ-021 LOCK: each further transfer from g SHALL increment the 4-bit burst count.
REQ-022 LOCK SHALL return to IDLE with last <= g when any of the following holds: the count reaches BURST on a transfer; g becomes ineligible; ch_en[g] deasserts.
REQ-023 A channel becoming ineligible mid-burst SHALL end the burst without any pop from it.
REQ-024 With back-to-back eligibility and m_ready=1, throughput SHALL be one word per cycle, including across a channel switch (the IDLE search and the transfer happen in the same cycle).
REQ-025 No eligible channel SHALL produce no transfer; the FSM SHALL remain in IDLE and last SHALL be unchanged.

Reset
REQ-026 While rst=1: state=IDLE, last=NCH-1, burst count=0, m_valid=0, m_data=0, m_ch=0, fifo_rd=0.
REQ-027 Reset mid-burst SHALL drop any held output word without popping; channel 0 SHALL be the first search candidate after release.

Configuration
REQ-028 Macro FIFO_DRAIN_ARB_PRIO_EN defined: channel 0 SHALL be strict high priority.
- In IDLE, an eligible channel 0 SHALL be granted regardless of last.
- In LOCK on g != 0, the burst SHALL end after the current transfer when channel 0 is eligible.
REQ-029 Macro not defined: pure round-robin, and channel 0 SHALL have no special treatment.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, LOCK) and the CHW function (clog2).
REQ-031 The rotate-and-find-first search SHALL be one sub-module, rr_pick (inputs: eligible mask, last; outputs: index, found).

Verification
REQ-032 All four channels each hold 8 words, m_ready=1, BURST=4 -> order ch0 x4, ch1 x4, ch2 x4, ch3 x4, ch0 x4, ...; m_valid continuously 1.
REQ-033 Only ch2 non-empty holding 3 words, BURST=4 -> 3 words with m_ch=2, then m_valid=0; FSM in IDLE with last=2.
REQ-034 m_ready held 0 for 5 cycles with a word pending -> m_data and m_ch stable; fifo_rd=0 throughout; no word lost or duplicated.
REQ-035 ch_en[1] cleared after the 2nd word of a ch1 burst -> no further ch1 pops; the next grant goes to ch2.
REQ-036 rst pulsed mid-burst on ch3 -> the next cycle m_valid=0 and fifo_rd=0; the first grant after release goes to ch0 if it is eligible.
REQ-037 With FIFO_DRAIN_ARB_PRIO_EN, ch0 fills during a ch2 burst -> exactly one more ch2 word, then ch0 is granted.
